// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes and FSM states.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_align.sv
// Little-endian lane extraction with sign/zero extension, and store byte-merge
// of right-aligned write data into the addressed doubleword.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [63:0] rdw_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] ldata_o,
  output logic [63:0] mdw_o
);

  logic [63:0] sh;
  logic [63:0] wsh;
  logic [7:0]  base_mask;
  logic [7:0]  lane_mask;
  logic        sx;

  assign sh  = rdw_i >> {lane_i, 3'b000};
  assign wsh = wdata_i << {lane_i, 3'b000};
  assign sx  = ~unsigned_i;

  always_comb begin
    ldata_o   = sh;
    base_mask = 8'hFF;
    unique case (size_i)
      SZ_B: begin
        ldata_o   = {{56{sx & sh[7]}}, sh[7:0]};
        base_mask = 8'h01;
      end
      SZ_H: begin
        ldata_o   = {{48{sx & sh[15]}}, sh[15:0]};
        base_mask = 8'h03;
      end
      SZ_W: begin
        ldata_o   = {{32{sx & sh[31]}}, sh[31:0]};
        base_mask = 8'h0F;
      end
      SZ_D: begin
        ldata_o   = sh;
        base_mask = 8'hFF;
      end
    endcase
  end

  assign lane_mask = base_mask << lane_i;

  always_comb begin
    mdw_o = rdw_i;
    for (int b = 0; b < 8; b++)
      if (lane_mask[b]) mdw_o[8*b +: 8] = wsh[8*b +: 8];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-request data memory controller: IDLE -> WAIT (LATENCY cycles) -> RESP,
// with the memory access performed only on the WAIT-to-RESP transition.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int DEPTH_DW = 512,
  parameter int LATENCY  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int AW = $clog2(DEPTH_DW);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [63:0] mem [DEPTH_DW];

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q, resp_valid_q, resp_err_q;
  logic [XLEN-1:0]   resp_rdata_q;
  logic              we_q, uns_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [2:0]        lane_q;
  size_e             size_q;
  logic [XLEN-1:0]   wdata_q;

  logic              misal_d, oor_d, err_d, mem_we;
  logic [63:0]       rdw, ldata, store_dw;

  always_comb begin
    misal_d = 1'b0;
    unique case (size_e'(req_size))
      SZ_B: misal_d = 1'b0;
      SZ_H: misal_d = req_addr[0];
      SZ_W: misal_d = |req_addr[1:0];
      SZ_D: misal_d = |req_addr[2:0];
    endcase
  end

  assign oor_d = |req_addr[XLEN-1:AW+3];
  assign err_d = misal_d | oor_d;
  assign rdw   = mem[idx_q];

  dmem_align u_align (
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdw_i      (rdw),
    .wdata_i    (wdata_q),
    .ldata_o    (ldata),
    .mdw_o      (store_dw)
  );

  // Store commits on the same edge that raises resp_valid; a reset in WAIT cancels it.
  assign mem_we = (state_q == WAIT) && (cnt_q == 4'd0) && we_q && !err_q && !rst;

  always_ff @(posedge clk)
    if (mem_we) mem[idx_q] <= store_dw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          we_q        <= req_we;
          uns_q       <= req_unsigned;
          err_q       <= err_d;
          idx_q       <= req_addr[3 +: AW];
          lane_q      <= req_addr[2:0];
          size_q      <= size_e'(req_size);
          wdata_q     <= req_wdata;
          cnt_q       <= CNT_INIT;
          req_ready_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: if (cnt_q == 4'd0) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_q;
          resp_rdata_q <= (err_q || we_q) ? '0 : ldata;
          state_q      <= RESP;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter XLEN, default 64, data and address width in bits; only 64 is supported.
REQ-002 Parameter DEPTH_DW, default 512, memory depth in 64-bit doublewords; must be a power of two.
REQ-003 Parameter LATENCY, default 2, cycles from request accept to resp_valid; must be between 1 and 15.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  XLEN  byte address.
REQ-010 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-012 req_wdata  input  XLEN  store data, right-aligned (low bytes used).
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  consumer accepts the response.
REQ-015 resp_rdata  output  XLEN  load result; 0 for stores and for errors.
REQ-016 resp_err  output  1  the access was misaligned or out of range.

Function
REQ-017 The controller SHALL use three FSM states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 A request is accepted when req_valid and req_ready are both 1; all req_* fields SHALL be captured in that cycle.
REQ-019 On accept the state SHALL go to WAIT and the latency counter SHALL load LATENCY-1.
REQ-020 In WAIT the counter SHALL decrement each cycle; when it reaches 0, the state SHALL go to RESP in the next cycle.
REQ-021 resp_valid SHALL therefore rise exactly LATENCY cycles after the accept edge; for LATENCY=1 it rises on the edge after accept.
REQ-022 The memory access SHALL occur only on the WAIT-to-RESP transition: the store commits, or the load data is registered into resp_rdata.
REQ-023 In RESP, resp_valid, resp_rdata and resp_err SHALL hold steady until resp_ready is 1.
REQ-024 On the resp_ready handshake the state SHALL return to IDLE; resp_valid SHALL drop and a new request SHALL be acceptable in the following cycle, with no back-to-back accept in the handshake cycle.
REQ-025 Byte ordering SHALL be little-endian.
REQ-026 The doubleword index SHALL be req_addr[3 +: log2(DEPTH_DW)].
REQ-027 The byte lane SHALL be req_addr[2:0].
REQ-028 A store SHALL write only the 1, 2, 4 or 8 addressed bytes; all other bytes in that doubleword are unchanged.
REQ-029 A load SHALL extract the addressed bytes and extend them to XLEN, by sign or zero per req_unsigned.
REQ-030 A size-3 load SHALL ignore req_unsigned.
REQ-031 Misalignment SHALL be defined as req_addr modulo (1 << req_size) not equal to 0.
REQ-032 Out of range SHALL be defined as req_addr >= DEPTH_DW*8.
REQ-033 Either error condition SHALL set resp_err=1 and resp_rdata=0, perform no write, and keep the full LATENCY timing.
REQ-034 req_* inputs SHALL be ignored outside IDLE.
REQ-035 resp_ready SHALL be ignored outside RESP.

Reset
REQ-036 While rst=1, the next state SHALL be IDLE, with counter=0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready SHALL read 1 from the first cycle after rst deasserts.
REQ-037 rst asserted during WAIT SHALL abandon the transaction: no store commits and no response is produced.
REQ-038 Memory contents SHALL NOT be reset, so the bench can preload them with $readmemh.

Structure
REQ-039 A shared package dmem_pkg SHALL hold the size encoding (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state enum.
REQ-040 The storage SHALL be an array named mem of DEPTH_DW x 64 bits, readable and writable hierarchically by $readmemh and $writememh.
REQ-041 Lane extraction, sign/zero extension and store byte-merge SHALL live in one combinational sub-module, dmem_align.

Verification
REQ-042 Preload mem[0]=0x8877665544332211; load, addr=0x1, size=0, signed, LATENCY=2 -> resp_valid 2 cycles after accept, rdata=0x0000000000000022.
REQ-043 Preload mem[0]=0x00000000000000F0; load, addr=0x0, size=0 -> signed gives rdata=0xFFFFFFFFFFFFFFF0, unsigned gives 0x00000000000000F0.
REQ-044 Store, addr=0xA, size=1, wdata=0xBEEF, onto mem[1]=0 -> mem[1]=0x00000000BEEF0000; a following double load of 0x8 returns the same value.
REQ-045 Store, addr=0x3, size=2 -> resp_err=1 and mem unchanged; load, addr=DEPTH_DW*8, size=3 -> resp_err=1 and rdata=0.
REQ-046 Load, with resp_ready held 0 for 5 cycles -> resp_valid, resp_rdata and resp_err stable all 5 cycles, and req_ready=0 throughout.
REQ-047 Store accepted, then rst pulsed 1 cycle later with LATENCY=3 -> target doubleword unchanged, resp_valid never 1, req_ready=1 the cycle after reset.
